// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C open-drain pad slice.
package i2c_pkg;
    localparam int I2C_SYNC_STAGES = 2;
    localparam int I2C_FILT_LEN    = 3;

    typedef enum logic {
        PAD_RELEASED  = 1'b0,
        PAD_DRIVE_LOW = 1'b1
    } pad_state_e;
endpackage

// File: rtl/i2c_sync_filter.sv
// Line-input synchronizer, majority-free glitch filter (all-equal window) and
// registered edge pulses aligned with the filtered level.
module i2c_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILT_LEN-1:0]    filt_q, filt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   all_hi, all_lo;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = line_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        filt_d    = filt_q;
        filt_d[0] = sync_q[SYNC_STAGES-1];
        for (int i = 1; i < FILT_LEN; i++) filt_d[i] = filt_q[i-1];
    end

    assign all_hi = &filt_q;
    assign all_lo = ~|filt_q;

    // Pulses are computed from the same condition that flips the level, so they
    // land in the very cycle the new level first appears.
    always_comb begin
        level_d = level_q;
        if (all_hi)      level_d = 1'b1;
        else if (all_lo) level_d = 1'b0;
        rise_d = all_hi & ~level_q;
        fall_d = all_lo &  level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            filt_q  <= '1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/i2c_od_pad.sv
// Open-drain pad for one I2C line: low-only driver, filtered line readback,
// edge pulses and a conflict flag for arbitration loss / clock stretching.
module i2c_od_pad
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILT_LEN    = I2C_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic x_out,
    input  logic x_tris,
    inout  wire  x,
    output logic x_in,
    output logic x_rise,
    output logic x_fall,
    output logic x_conflict
);
    localparam int DLY = SYNC_STAGES + FILT_LEN + 1;

    pad_state_e     pad_st;
    logic           drive_low;
    logic [DLY-1:0] rel_q, rel_d;

    // Only a clean 0 request pulls low; X/Z on x_out leaves the pad released.
    assign drive_low = ~rst & ~x_tris & (x_out === 1'b0);
    assign pad_st    = drive_low ? PAD_DRIVE_LOW : PAD_RELEASED;
    assign x         = (pad_st == PAD_DRIVE_LOW) ? 1'b0 : 1'bz;

    i2c_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sf (
        .clk     (clk),
        .rst     (rst),
        .line_i  (x),
        .level_o (x_in),
        .rise_o  (x_rise),
        .fall_o  (x_fall)
    );

    // Release intent delayed to match the readback path, so our own pull-down
    // and the filtered low arrive together and never look like a conflict.
    always_comb begin
        rel_d    = rel_q;
        rel_d[0] = ~drive_low;
        for (int i = 1; i < DLY; i++) rel_d[i] = rel_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rel_q <= '1;
        else     rel_q <= rel_d;
    end

    assign x_conflict = rel_q[DLY-1] & ~x_in;
endmodule

// File: tb/tb_i2c_od_pad.sv
// Two pads sharing one pulled-up net, directed steps with a scoreboard queue.
module tb_i2c_od_pad;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_out = 1'b1, a_tris = 1'b1;
    logic b_out = 1'b1, b_tris = 1'b1;
    logic frc = 1'b0;
    wire  x;
    logic a_in, a_rise, a_fall, a_conf;
    logic b_in, b_rise, b_fall, b_conf;

    int nasrt = 0;
    int nfail = 0;

    typedef struct {
        string      tag;
        logic [8:0] v;
    } exp_t;
    exp_t sb[$];

    pullup (x);
    assign x = frc ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_od_pad u_a (
        .clk(clk), .rst(rst), .x_out(a_out), .x_tris(a_tris), .x(x),
        .x_in(a_in), .x_rise(a_rise), .x_fall(a_fall), .x_conflict(a_conf)
    );
    i2c_od_pad u_b (
        .clk(clk), .rst(rst), .x_out(b_out), .x_tris(b_tris), .x(x),
        .x_in(b_in), .x_rise(b_rise), .x_fall(b_fall), .x_conflict(b_conf)
    );

    // {x, a_in, a_rise, a_fall, a_conf, b_in, b_rise, b_fall, b_conf}
    function automatic logic [8:0] e(input logic xv,
                                     input logic ai, input logic ar, input logic af, input logic ac,
                                     input logic bi, input logic br, input logic bf, input logic bc);
        return {xv, ai, ar, af, ac, bi, br, bf, bc};
    endfunction

    // Push the expectation, advance n rising edges, sample 1ns later and compare.
    task automatic chk(input int n, input string tag, input logic [8:0] v);
        exp_t ex;
        logic [8:0] obs;
        sb.push_back('{tag: tag, v: v});
        repeat (n) @(posedge clk);
        #1;
        obs = {x, a_in, a_rise, a_fall, a_conf, b_in, b_rise, b_fall, b_conf};
        ex  = sb.pop_front();
        nasrt++;
        assert (obs === ex.v) else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b", ex.tag, obs, ex.v);
        end
    endtask

    initial begin
        // Reset held, both released.
        chk(2, "reset_idle", e(1, 1,0,0,0, 1,0,0,0));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) chk(1, "idle", e(1, 1,0,0,0, 1,0,0,0));

        // A pulls low.
        a_tris = 1'b0; a_out = 1'b0;
        chk(0, "a_low_imm",    e(0, 1,0,0,0, 1,0,0,0));
        chk(5, "a_low_e5",     e(0, 1,0,0,0, 1,0,0,0));
        chk(1, "a_low_e6",     e(0, 0,0,1,0, 0,0,1,1));
        chk(1, "a_low_e7",     e(0, 0,0,0,0, 0,0,0,1));

        // B takes over the low, A releases: A sees conflict, B stops seeing one.
        b_tris = 1'b0; b_out = 1'b0; a_out = 1'b1;
        chk(0, "swap_imm",     e(0, 0,0,0,0, 0,0,0,1));
        chk(5, "swap_e5",      e(0, 0,0,0,0, 0,0,0,1));
        chk(1, "swap_e6",      e(0, 0,0,0,1, 0,0,0,0));

        // A: tris wins over out=0; then B releases and the line rises.
        a_tris = 1'b1; a_out = 1'b0;
        chk(0, "a_tris_wins",  e(0, 0,0,0,1, 0,0,0,0));
        b_tris = 1'b1;
        chk(0, "b_rel_imm",    e(1, 0,0,0,1, 0,0,0,0));
        chk(5, "b_rel_e5",     e(1, 0,0,0,1, 0,0,0,0));
        chk(1, "b_rel_e6",     e(1, 1,1,0,0, 1,1,0,0));
        chk(1, "b_rel_e7",     e(1, 1,0,0,0, 1,0,0,0));
        a_out = 1'b1;

        // 2-cycle glitch is swallowed.
        frc = 1'b1;
        chk(0, "glitch2_imm",  e(0, 1,0,0,0, 1,0,0,0));
        chk(2, "glitch2_e2",   e(0, 1,0,0,0, 1,0,0,0));
        frc = 1'b0;
        for (int i = 0; i < 9; i++) chk(1, "glitch2_quiet", e(1, 1,0,0,0, 1,0,0,0));

        // 4-cycle low passes: fall, conflict while low, then rise.
        frc = 1'b1;
        chk(4, "low4_e4",      e(0, 1,0,0,0, 1,0,0,0));
        frc = 1'b0;
        chk(1, "low4_e5",      e(1, 1,0,0,0, 1,0,0,0));
        chk(1, "low4_e6",      e(1, 0,0,1,1, 0,0,1,1));
        chk(3, "low4_e9",      e(1, 0,0,0,1, 0,0,0,1));
        chk(1, "low4_e10",     e(1, 1,1,0,0, 1,1,0,0));
        chk(1, "low4_e11",     e(1, 1,0,0,0, 1,0,0,0));

        // Reset while A drives low, then release reset with A still low.
        a_tris = 1'b0; a_out = 1'b0;
        chk(8, "pre_rst",      e(0, 0,0,0,0, 0,0,0,1));
        rst = 1'b1;
        chk(0, "rst_imm",      e(1, 1,0,0,0, 1,0,0,0));
        chk(2, "rst_hold",     e(1, 1,0,0,0, 1,0,0,0));
        rst = 1'b0;
        chk(0, "post_rst_imm", e(0, 1,0,0,0, 1,0,0,0));
        chk(5, "post_rst_e5",  e(0, 1,0,0,0, 1,0,0,0));
        chk(1, "post_rst_e6",  e(0, 0,0,1,0, 0,0,1,1));
        chk(1, "post_rst_e7",  e(0, 0,0,0,0, 0,0,0,1));

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end
endmodule
